// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 4-digit seven-segment scan driver.
// Four BCD digits plus decimal points are loaded over a valid/ready port
// into a pending buffer. They are promoted to the displayed set only at a
// frame wrap, so a frame never shows a mix of old and new digits.
// A per-slot brightness duty gates digit_en.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN. When defined, leading
// zero digits 3..1 are blanked. Digit 0 is always shown.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 2500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [2:0]  brightness,
    output logic [6:0]  segments,
    output logic        dp_out,
    output logic [3:0]  digit_en,
    output logic        frame_done
);

    localparam int            PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_scan_idx;
    logic [15:0]   r_active_digits;
    logic [3:0]    r_active_dp;
    logic [15:0]   r_pend_digits;
    logic [3:0]    r_pend_dp;
    logic          r_pend_full;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_digit_en;

    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_accept;
    logic [19:0]   w_on_cycles;
    logic          w_lit;
    logic [15:0]   w_upper;
    logic [3:0]    w_cur_bcd;
    logic          w_blank;
    logic [6:0]    w_seg_dec;

    assign w_slot_end  = ena & (r_presc == P_LAST);
    assign w_frame_end = w_slot_end & (r_scan_idx == 2'd3);
    assign load_ready  = ena & ~r_pend_full;
    assign w_accept    = load_valid & load_ready;
    assign frame_done  = w_frame_end;

    // Lit-cycle count per slot: ((brightness+1)*SCAN_DIV)>>3, fits in 20 bits for SCAN_DIV <= 2^16.
    assign w_on_cycles = 20'((({17'd0, brightness} + 20'd1) * 20'(SCAN_DIV)) >> 3);
    assign w_lit       = (20'(r_presc) < w_on_cycles);

    // The selected digit sits in the low nibble of w_upper; the rest are the higher digits.
    assign w_upper     = r_active_digits >> {r_scan_idx, 2'b00};
    assign w_cur_bcd   = w_upper[3:0];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign w_blank = (r_scan_idx != 2'd0) && (w_upper == 16'd0);
`else
    assign w_blank = 1'b0;
`endif

    // BCD to a..g decode; codes 10..15 are blank.
    always_comb begin
        w_seg_dec = 7'h00;
        case (w_cur_bcd)
            4'd0:    w_seg_dec = 7'h3F;
            4'd1:    w_seg_dec = 7'h06;
            4'd2:    w_seg_dec = 7'h5B;
            4'd3:    w_seg_dec = 7'h4F;
            4'd4:    w_seg_dec = 7'h66;
            4'd5:    w_seg_dec = 7'h6D;
            4'd6:    w_seg_dec = 7'h7D;
            4'd7:    w_seg_dec = 7'h07;
            4'd8:    w_seg_dec = 7'h7F;
            4'd9:    w_seg_dec = 7'h6F;
            default: w_seg_dec = 7'h00;
        endcase
        if (w_blank) begin
            w_seg_dec = 7'h00;
        end
    end

    // Scan position: prescaler wraps each slot and advances the digit index; both hold while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_scan_idx <= 2'd0;
        end else if (ena) begin
            if (r_presc == P_LAST) begin
                r_presc    <= '0;
                r_scan_idx <= r_scan_idx + 2'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Pending/active buffers. A load on the wrap cycle lands in pending and waits a full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_digits <= 16'd0;
            r_active_dp     <= 4'd0;
            r_pend_digits   <= 16'd0;
            r_pend_dp       <= 4'd0;
            r_pend_full     <= 1'b0;
        end else begin
            if (w_frame_end && r_pend_full) begin
                r_active_digits <= r_pend_digits;
                r_active_dp     <= r_pend_dp;
                r_pend_full     <= 1'b0;
            end
            if (w_accept) begin
                r_pend_digits <= digits_in;
                r_pend_dp     <= dp_in;
                r_pend_full   <= 1'b1;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan position; all dark while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= 7'h00;
            r_dp       <= 1'b0;
            r_digit_en <= 4'h0;
        end else if (ena) begin
            r_seg      <= w_seg_dec;
            r_dp       <= r_active_dp[r_scan_idx];
            r_digit_en <= w_lit ? (4'b0001 << r_scan_idx) : 4'h0;
        end else begin
            r_seg      <= 7'h00;
            r_dp       <= 1'b0;
            r_digit_en <= 4'h0;
        end
    end

    assign segments = r_seg;
    assign dp_out   = r_dp;
    assign digit_en = r_digit_en;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (SCAN_DIV=8). A frame-position model predicts
// every output each cycle, and a few literal checks pin the model itself.
module tb_seg7_scan_driver;

    localparam int S = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [2:0]  brightness;
    logic [6:0]  segments;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver #(.SCAN_DIV(S)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .load_valid(load_valid), .load_ready(load_ready),
        .digits_in(digits_in), .dp_in(dp_in), .brightness(brightness),
        .segments(segments), .dp_out(dp_out), .digit_en(digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model state: position within the frame, active/pending data, predicted registered outputs.
    logic [6:0] seg_tab [16];
    int         m_pos;
    int         m_act, m_actdp, m_pend, m_penddp;
    bit         m_pfull;
    int         e_seg, e_dp, e_en;
    int         m_idx, m_p, m_thr, m_dig;
    bit         m_acc, m_blank;

    initial begin
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h00;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_act = 0; m_actdp = 0; m_pend = 0; m_penddp = 0; m_pfull = 0;
            e_seg = 0; e_dp = 0; e_en = 0;
        end else if (ena) begin
            m_idx = m_pos / S;
            m_p   = m_pos % S;
            m_thr = ((int'(brightness) + 1) * S) / 8;
            m_dig = (m_act >> (4 * m_idx)) & 15;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            m_blank = (m_idx > 0) && ((m_act >> (4 * m_idx)) == 0);
`else
            m_blank = 0;
`endif
            e_seg = m_blank ? 0 : int'(seg_tab[m_dig]);
            e_dp  = (m_actdp >> m_idx) & 1;
            e_en  = (m_p < m_thr) ? (1 << m_idx) : 0;
            m_acc = load_valid && !m_pfull;
            if (m_pos == 4 * S - 1 && m_pfull) begin
                m_act = m_pend; m_actdp = m_penddp; m_pfull = 0;
            end
            if (m_acc) begin
                m_pend = int'(digits_in); m_penddp = int'(dp_in); m_pfull = 1;
            end
            m_pos = (m_pos + 1) % (4 * S);
        end else begin
            e_seg = 0; e_dp = 0; e_en = 0;
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        check("digit_en",   int'(digit_en),   e_en);
        check("segments",   int'(segments),   e_seg);
        check("dp_out",     int'(dp_out),     e_dp);
        check("load_ready", int'(load_ready), int'(ena && !m_pfull));
        check("frame_done", int'(frame_done), int'(rst_n && ena && m_pos == 4 * S - 1));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_en(input logic [3:0] pat, input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (digit_en == pat) begin ok = 1; break; end
            cyc();
        end
        if (!ok) check({"timeout ", name}, 0, 1);
    endtask

    task automatic wait_fd();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (frame_done) begin ok = 1; break; end
            cyc();
        end
        if (!ok) check("timeout frame_done", 0, 1);
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p);
        bit ok = 0;
        bit rdy;
        load_valid = 1; digits_in = d; dp_in = p;
        for (int i = 0; i < 200; i++) begin
            rdy = load_ready;
            cyc();
            if (rdy) begin ok = 1; break; end
        end
        load_valid = 0;
        if (!ok) check("timeout load", 0, 1);
    endtask

    int cnt;

    initial begin
        rst_n = 0; ena = 1; load_valid = 0; digits_in = 0; dp_in = 0; brightness = 3'd7;
        #1;
        check("reset segments", int'(segments), 0);
        check("reset load_ready", int'(load_ready), 1);
        repeat (3) cyc();
        rst_n = 1;
        repeat (13) cyc();
        // reset mid-operation, then release
        rst_n = 0; #4; rst_n = 1;
        cyc();
        check("first slot digit_en", int'(digit_en), 1);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (segments != 7'h3F) cnt++;
            cyc();
        end
        check("zero frame segments", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (frame_done) cnt++;
            cyc();
        end
        check("frame_done per 64", cnt, 2);

        // load 0x1234, dp on digit 2, mid-frame
        repeat (5) cyc();
        load_word(16'h1234, 4'b0100);
        check("ready low after load", int'(load_ready), 0);
        wait_fd();
        cyc();
        check("ready after frame", int'(load_ready), 1);
        wait_en(4'b0001, "d0");
        check("d0 seg", int'(segments), 7'h66);
        wait_en(4'b0010, "d1");
        check("d1 seg", int'(segments), 7'h4F);
        wait_en(4'b0100, "d2");
        check("d2 seg", int'(segments), 7'h5B);
        check("d2 dp", int'(dp_out), 1);
        wait_en(4'b1000, "d3");
        check("d3 seg", int'(segments), 7'h06);

        // back-to-back loads, second held until ready
        load_word(16'h5678, 4'b0001);
        load_word(16'h9012, 4'b1000);
        repeat (80) cyc();

        // brightness 1: 2 lit cycles per slot
        brightness = 3'd1;
        cyc(); cyc();
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (digit_en != 4'h0) cnt++;
            cyc();
        end
        check("lit cycles b=1", cnt, 8);
        brightness = 3'd7;

        // enable gap mid-slot
        wait_en(4'b0100, "gap start");
        repeat (3) cyc();
        ena = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (frame_done || load_ready || digit_en != 0 || segments != 0) cnt++;
        end
        check("gap quiet", cnt, 0);
        ena = 1;
        repeat (40) cyc();

        // non-BCD code and leading zeros
        load_word(16'h00A5, 4'b0000);
        wait_fd();
        cyc();
        wait_en(4'b0001, "a5 d0");
        check("a5 d0 seg", int'(segments), 7'h6D);
        wait_en(4'b0010, "a5 d1");
        check("a5 d1 blank", int'(segments), 0);
        wait_en(4'b1000, "a5 d3");
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("a5 d3 seg", int'(segments), 0);
`else
        check("a5 d3 seg", int'(segments), 7'h3F);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) brightness = 3'($urandom_range(0, 7));
            load_valid = ($urandom_range(0, 3) == 0);
            digits_in  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in      = 4'($urandom_range(0, 15));
            if (i == 300) begin
                rst_n = 0; #4; rst_n = 1;
            end
            cyc();
        end
        load_valid = 0;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
